// File: rtl/sram_ctrl_pkg.sv
// Shared types for the Avalon-to-async-SRAM bridge: the access FSM states and
// the address bit that selects which half-word of a 32-bit word is accessed.
`timescale 1ns/1ps
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam logic SRAM_HALF_LO = 1'b0;
  localparam logic SRAM_HALF_HI = 1'b1;

endpackage

// File: rtl/avalon_sram_controller.sv
// Splits each 32-bit Avalon-MM access into two 16-bit async SRAM cycles, low half first.
// Each half-word phase lasts ACCESS_CYCLES clocks. Byte-enable-empty halves of a write are skipped.
//
// state | meaning
// IDLE  | waiting for avn_read / avn_write
// LO    | low half-word SRAM cycle (address bit 0 = 0)
// HI    | high half-word SRAM cycle (address bit 0 = 1)
// DONE  | one-cycle completion, waitrequest low
`timescale 1ns/1ps
module avalon_sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int SRAM_AW       = 25,
  parameter int SRAM_DW       = 16,
  parameter int AVN_AW        = SRAM_AW + 1,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 avn_read,
  input  logic                 avn_write,
  input  logic [AVN_AW-1:0]    avn_address,
  input  logic [31:0]          avn_writedata,
  input  logic [3:0]           avn_byteenable,
  output logic [31:0]          avn_readdata,
  output logic                 avn_waitrequest,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [SRAM_DW/8-1:0] sram_be_n,
  output logic [SRAM_AW-1:0]   sram_addr,
  inout  wire  [SRAM_DW-1:0]   sram_dq
);

  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

  sram_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AVN_AW-1:0] addr_q, addr_nx;
  logic [31:0] wdata_q, wdata_nx;
  logic [3:0] be_q, be_nx;
  logic is_wr_q, wr_nx;
  logic [SRAM_DW-1:0] rd_lo;
  logic last, in_phase_nx, half_nx, drive;
  logic [1:0] be_half_nx;
  logic [SRAM_DW-1:0] dq_out;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^avn_address[1:0];
  assign last = (cnt == CNT_LAST);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    be_nx    = be_q;
    wr_nx    = is_wr_q;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        // a simultaneous read+write is taken as a write
        if (avn_write) begin
          wr_nx    = 1'b1;
          addr_nx  = avn_address;
          wdata_nx = avn_writedata;
          be_nx    = avn_byteenable;
          if (avn_byteenable == 4'b0000)       state_nx = DONE;
          else if (avn_byteenable[1:0] == 2'b00) state_nx = HI;
          else                                 state_nx = LO;
        end else if (avn_read) begin
          wr_nx    = 1'b0;
          addr_nx  = avn_address;
          be_nx    = 4'b1111;
          state_nx = LO;
        end
      end
      LO: begin
        if (last) begin
          cnt_nx   = '0;
          state_nx = (is_wr_q && be_q[3:2] == 2'b00) ? DONE : HI;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      HI: begin
        if (last) begin
          cnt_nx   = '0;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // strobes are registered from the next-state view so they line up with the phase
  assign in_phase_nx = (state_nx == LO) || (state_nx == HI);
  assign half_nx     = (state_nx == HI) ? SRAM_HALF_HI : SRAM_HALF_LO;
  assign be_half_nx  = half_nx ? be_nx[3:2] : be_nx[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      be_q            <= '0;
      is_wr_q         <= 1'b0;
      rd_lo           <= '0;
      avn_readdata    <= '0;
      avn_waitrequest <= 1'b1;
      sram_ce_n       <= 1'b1;
      sram_oe_n       <= 1'b1;
      sram_we_n       <= 1'b1;
      sram_be_n       <= '1;
      sram_addr       <= '0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      addr_q          <= addr_nx;
      wdata_q         <= wdata_nx;
      be_q            <= be_nx;
      is_wr_q         <= wr_nx;
      avn_waitrequest <= (state_nx != DONE);
      sram_ce_n       <= !in_phase_nx;
      sram_oe_n       <= !(in_phase_nx && !wr_nx);
      // we_n rises one cycle before the phase ends to hold address/data past the edge
      sram_we_n       <= !(in_phase_nx && wr_nx && (cnt_nx != CNT_LAST));
      sram_be_n       <= in_phase_nx ? ~be_half_nx : '1;
      if (in_phase_nx)
        sram_addr <= {addr_nx[AVN_AW-1:2], half_nx};
      if (!is_wr_q && last) begin
        if (state == LO) rd_lo <= sram_dq;
        if (state == HI) avn_readdata <= {sram_dq, rd_lo};
      end
    end
  end

  assign drive   = is_wr_q && ((state == LO) || (state == HI));
  assign dq_out  = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
  assign sram_dq = drive ? dq_out : 'z;

endmodule

// File: tb/tb_avalon_sram_controller.sv
// Bench for avalon_sram_controller: directed Avalon requests against a behavioural
// async SRAM, with a completion scoreboard checking latency and read data.
`timescale 1ns/1ps
module tb_avalon_sram_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic avn_read = 1'b0, avn_write = 1'b0;
  logic [25:0] avn_address = '0;
  logic [31:0] avn_writedata = '0;
  logic [3:0] avn_byteenable = '0;
  logic [31:0] avn_readdata;
  logic avn_waitrequest;
  logic sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0] sram_be_n;
  logic [24:0] sram_addr;
  wire [15:0] sram_dq;

  logic [15:0] mem [0:255];
  logic probe_en = 1'b0;
  int cyc = 0;
  int pass_cnt = 0, total_cnt = 0;
  int oe_low, we_low, ce_low;
  logic [1:0] be_seen;
  logic [24:0] addr_seen;

  typedef struct {
    int          done_cyc;
    logic        is_rd;
    logic [31:0] rdata;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  avalon_sram_controller dut (
    .clk(clk), .rst(rst),
    .avn_read(avn_read), .avn_write(avn_write),
    .avn_address(avn_address), .avn_writedata(avn_writedata),
    .avn_byteenable(avn_byteenable), .avn_readdata(avn_readdata),
    .avn_waitrequest(avn_waitrequest),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n), .sram_addr(sram_addr), .sram_dq(sram_dq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural SRAM and a bench-side driver used to prove the bus is released
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
  assign sram_dq = probe_en ? 16'hC3C3 : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_be_n[0]) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!sram_be_n[1]) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  always @(posedge clk) begin
    #1;
    if (!sram_oe_n) oe_low++;
    if (!sram_we_n) we_low++;
    if (!sram_ce_n) begin
      ce_low++;
      be_seen   = sram_be_n;
      addr_seen = sram_addr;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst && !avn_waitrequest) begin
      if (exp_q.size() == 0) begin
        check("unexpected completion", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, " done cycle"}, 32'(cyc), 32'(e.done_cyc));
        if (e.is_rd) check({e.name, " readdata"}, avn_readdata, e.rdata);
      end
    end
  end

  task automatic req(input logic rd, input logic wr, input logic [25:0] a,
                     input logic [31:0] d, input logic [3:0] be, input int lat,
                     input logic [31:0] exp_rd, input string nm);
    bit got;
    exp_t e;
    @(negedge clk);
    avn_read = rd; avn_write = wr; avn_address = a;
    avn_writedata = d; avn_byteenable = be;
    oe_low = 0; we_low = 0; ce_low = 0; be_seen = 2'b11; addr_seen = '0;
    e.done_cyc = cyc + lat; e.is_rd = rd && !wr; e.rdata = exp_rd; e.name = nm;
    exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!avn_waitrequest) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check({nm, " timeout"}, 32'd0, 32'd1);
    avn_read = 1'b0; avn_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset waitrequest", 32'(avn_waitrequest), 32'd1);
    check("reset readdata", avn_readdata, 32'd0);
    check("reset strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    check("reset be_n", 32'(sram_be_n), 32'd3);
    check("reset addr", 32'(sram_addr), 32'd0);
    rst = 1'b1;

    req(1'b0, 1'b1, 26'h100, 32'hDEADBEEF, 4'b1111, 5, 32'h0, "full write");
    check("full write lo", 32'(mem[8'h80]), 32'h0000BEEF);
    check("full write hi", 32'(mem[8'h81]), 32'h0000DEAD);
    check("full write we_n lows", 32'(we_low), 32'd2);
    check("full write ce_n lows", 32'(ce_low), 32'd4);
    check("full write oe_n lows", 32'(oe_low), 32'd0);

    req(1'b1, 1'b0, 26'h100, 32'h0, 4'b0000, 5, 32'hDEADBEEF, "read back");
    check("read oe_n lows", 32'(oe_low), 32'd4);
    check("read we_n lows", 32'(we_low), 32'd0);

    req(1'b0, 1'b1, 26'h100, 32'h00AA0000, 4'b0100, 3, 32'h0, "hi-only write");
    check("hi-only ce_n lows", 32'(ce_low), 32'd2);
    check("hi-only be_n", 32'(be_seen), 32'd2);
    check("hi-only addr", 32'(addr_seen), 32'h81);
    check("hi-only mem hi", 32'(mem[8'h81]), 32'h0000DEAA);
    check("hi-only mem lo", 32'(mem[8'h80]), 32'h0000BEEF);
    check("readdata held", avn_readdata, 32'hDEADBEEF);

    req(1'b1, 1'b0, 26'h100, 32'h0, 4'b0000, 5, 32'hDEAABEEF, "partial read back");

    req(1'b0, 1'b1, 26'h100, 32'hFFFFFFFF, 4'b0000, 1, 32'h0, "empty write");
    check("empty write ce_n lows", 32'(ce_low), 32'd0);
    check("empty write mem", 32'(mem[8'h80]), 32'h0000BEEF);

    req(1'b0, 1'b1, 26'h108, 32'h00001234, 4'b0011, 3, 32'h0, "lo-only write");
    check("lo-only mem lo", 32'(mem[8'h84]), 32'h00001234);
    check("lo-only mem hi", 32'(mem[8'h85]), 32'h00000000);

    req(1'b0, 1'b1, 26'h104, 32'h11223344, 4'b1111, 5, 32'h0, "b2b write");
    req(1'b1, 1'b0, 26'h104, 32'h0, 4'b0000, 5, 32'h11223344, "b2b read");

    req(1'b1, 1'b1, 26'h10C, 32'hCAFEF00D, 4'b1111, 5, 32'h0, "read+write");
    check("read+write mem lo", 32'(mem[8'h86]), 32'h0000F00D);
    check("read+write mem hi", 32'(mem[8'h87]), 32'h0000CAFE);

    @(negedge clk);
    avn_read = 1'b1; avn_address = 26'h100;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort read strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    check("abort read waitrequest", 32'(avn_waitrequest), 32'd1);
    check("abort read readdata", avn_readdata, 32'd0);
    probe_en = 1'b1;
    #1;
    check("abort read bus released", 32'(sram_dq), 32'h0000C3C3);
    probe_en = 1'b0;
    avn_read = 1'b0;
    rst = 1'b1;
    req(1'b1, 1'b0, 26'h100, 32'h0, 4'b0000, 5, 32'hDEAABEEF, "read after reset");

    @(negedge clk);
    avn_write = 1'b1; avn_address = 26'h110;
    avn_writedata = 32'h12345678; avn_byteenable = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort write ce_n", 32'(sram_ce_n), 32'd1);
    probe_en = 1'b1;
    #1;
    check("abort write bus released", 32'(sram_dq), 32'h0000C3C3);
    probe_en = 1'b0;
    avn_write = 1'b0;
    rst = 1'b1;

    repeat (4) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
